// File: rtl/common_dffram_fifo_ctrl_pkg.sv
// Shared definitions for FIFOs built from the single-port DFF RAM macro.
// This file has no ports. It holds the RAM access type and helpers for depth,
// capacity (RAM depth plus the head register) and count width. Other
// DFF-RAM-based queues reuse these helpers.
package common_dffram_fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    RAM_IDLE  = 2'd0,
    RAM_WRITE = 2'd1,
    RAM_READ  = 2'd2
  } ram_op_e;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // The head register holds one entry in front of the RAM.
  function automatic int fifo_capacity(input int addr_width);
    return (1 << addr_width) + 1;
  endfunction

  // The width holds values from 0 to RAM_DEPTH, and also RAM_DEPTH+1.
  function automatic int fifo_cnt_w(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/common_dffram_fifo_ctrl_if.sv
// Push/pop handshake bundle for common_dffram_fifo_ctrl.
// Signals:
//   push_valid, push_data : producer to FIFO
//   push_ready            : FIFO to producer
//   pop_valid, pop_data   : FIFO to consumer
//   pop_ready             : consumer to FIFO
// Modports: slave is the FIFO side. master is the producer/consumer side.
interface common_dffram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  push_valid;
  logic                  push_ready;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop_valid;
  logic                  pop_ready;
  logic [DATA_WIDTH-1:0] pop_data;

  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data
  );

  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data
  );
endinterface

// File: rtl/common_dffram_fifo_ptr.sv
// Write/read pointers and RAM occupancy for a DFF-RAM-backed FIFO.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   clr          : synchronous clear, same effect as reset
//   inc_w, inc_r : a RAM write or a RAM read happened this cycle
//                  (the two never occur together)
//   wptr, rptr   : RAM addresses; they wrap modulo 1<<ADDR_WIDTH
//   ram_cnt      : number of entries held in the RAM, 0..1<<ADDR_WIDTH
module common_dffram_fifo_ptr #(
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  inc_w,
  input  logic                  inc_r,
  output logic [ADDR_WIDTH-1:0] wptr,
  output logic [ADDR_WIDTH-1:0] rptr,
  output logic [ADDR_WIDTH:0]   ram_cnt
);

  // A power-of-two depth lets the pointers wrap by simple overflow.
  // Full and empty come from ram_cnt, not from comparing the pointers.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
    end else begin
      if (inc_w) wptr <= wptr + ADDR_WIDTH'(1);
      if (inc_r) rptr <= rptr + ADDR_WIDTH'(1);
      case ({inc_w, inc_r})
        2'b10:   ram_cnt <= ram_cnt + (ADDR_WIDTH+1)'(1);
        2'b01:   ram_cnt <= ram_cnt - (ADDR_WIDTH+1)'(1);
        default: ram_cnt <= ram_cnt;
      endcase
    end
  end

endmodule

// File: rtl/common_dffram_fifo_ctrl.sv
// FIFO controller in front of a single-port DFF RAM. The RAM has one address,
// a write enable and combinational read data. A head register sits in front
// of the RAM, so capacity is (1<<ADDR_WIDTH)+1. Each cycle the single RAM port
// serves either a push write or a head refill read, never both.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   flush      : synchronous queue clear
//   fifo       : push/pop handshake (slave modport)
//   count      : total entries (head + RAM)
//   ram_addr, ram_en, ram_we, ram_din, ram_dout : RAM port
//   err        : sticky overflow/underflow flag; present only when
//                COMMON_DFFRAM_FIFO_ERRCHK_EN is defined
module common_dffram_fifo_ctrl
  import common_dffram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  common_dffram_fifo_ctrl_if.slave fifo,
  output logic [ADDR_WIDTH:0]     count,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [DATA_WIDTH-1:0]   ram_din,
  input  logic [DATA_WIDTH-1:0]   ram_dout
`ifdef COMMON_DFFRAM_FIFO_ERRCHK_EN
  ,
  output logic                    err
`endif
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int CNT_W = fifo_cnt_w(ADDR_WIDTH);

  logic                  head_valid;
  logic [DATA_WIDTH-1:0] head_data;
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [CNT_W-1:0]      ram_cnt;
  logic                  ram_empty;
  logic                  ram_full;
  logic                  pop_fire;
  logic                  push_fire;
  ram_op_e               ram_op;

  assign ram_empty = (ram_cnt == '0);
  assign ram_full  = (ram_cnt == CNT_W'(DEPTH));

  assign fifo.pop_valid = head_valid;
  assign fifo.pop_data  = head_data;

  // A pop seen during flush is discarded.
  assign pop_fire = head_valid & fifo.pop_ready & ~flush;

  // When the RAM holds data, a pop uses the port for a refill, so a push
  // must wait. This makes a combinational path from pop_ready.
  assign fifo.push_ready = ~flush & (ram_empty | (~ram_full & ~pop_fire));
  assign push_fire       = fifo.push_valid & fifo.push_ready;

  // A push goes to the RAM only when the head stays occupied this cycle.
  // If the RAM is non-empty, head_valid is already 1, so one test covers
  // both cases.
  always_comb begin
    ram_op = RAM_IDLE;
    if (!ram_empty && pop_fire)
      ram_op = RAM_READ;
    else if (push_fire && head_valid && !pop_fire)
      ram_op = RAM_WRITE;
  end

  assign ram_en   = (ram_op != RAM_IDLE);
  assign ram_we   = (ram_op == RAM_WRITE);
  assign ram_addr = ram_we ? wptr : rptr;
  assign ram_din  = fifo.push_data;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_valid <= 1'b0;
    end else if (ram_op == RAM_READ) begin
      head_data <= ram_dout;
    end else if (push_fire && ram_op != RAM_WRITE) begin
      head_valid <= 1'b1;
      head_data  <= fifo.push_data;
    end else if (pop_fire) begin
      head_valid <= 1'b0;
    end
  end

  common_dffram_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_ptr (
    .clk     (clk),
    .reset   (reset),
    .clr     (flush),
    .inc_w   (ram_op == RAM_WRITE),
    .inc_r   (ram_op == RAM_READ),
    .wptr    (wptr),
    .rptr    (rptr),
    .ram_cnt (ram_cnt)
  );

  assign count = ram_cnt + CNT_W'(head_valid);

`ifdef COMMON_DFFRAM_FIFO_ERRCHK_EN
  localparam int CAP = fifo_capacity(ADDR_WIDTH);

  always_ff @(posedge clk) begin
    if (reset || flush)
      err <= 1'b0;
    else if ((fifo.push_valid && !fifo.push_ready && count == CNT_W'(CAP)) ||
             (fifo.pop_ready && !head_valid))
      err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_common_dffram_fifo_ctrl.sv
module tb_common_dffram_fifo_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [2:0] count;
  logic [1:0] ram_addr;
  logic       ram_en;
  logic       ram_we;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
`ifdef COMMON_DFFRAM_FIFO_ERRCHK_EN
  logic       err;
`endif

  common_dffram_fifo_ctrl_if #(.DATA_WIDTH(8)) fif ();

  common_dffram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .fifo     (fif),
    .count    (count),
    .ram_addr (ram_addr),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
`ifdef COMMON_DFFRAM_FIFO_ERRCHK_EN
    ,
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  // DFF RAM: synchronous write, combinational read.
  logic [7:0] mem [4];
  always @(posedge clk) if (ram_en && ram_we) mem[ram_addr] <= ram_din;
  assign ram_dout = mem[ram_addr];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue model of the FIFO, plus RAM activity monitors.
  int   mq[$];
  int   wr_total = 0, rd_total = 0;
  bit   model_init = 0;
  bit   exp_err = 0;
  int   wr_addrs[$];
  int   ram_en_cycles = 0;

  always begin
    int  sz, rc;
    bit  m_pop, m_push, m_wr, m_rd, m_prdy, s_reset, s_flush, n_err;
    int  s_data;
    @(negedge clk);
    s_reset = reset; s_flush = flush; s_data = fif.push_data;
    m_pop = 0; m_push = 0; m_wr = 0; m_rd = 0; n_err = exp_err;
    if (ram_en) ram_en_cycles++;
    if (ram_en && ram_we) wr_addrs.push_back(int'(ram_addr));
    if (!s_reset && model_init) begin
      sz     = mq.size();
      rc     = (sz > 1) ? sz - 1 : 0;
      m_pop  = (sz > 0) && fif.pop_ready && !s_flush;
      m_prdy = !s_flush && (rc == 0 || (rc < 4 && !m_pop));
      m_push = fif.push_valid && m_prdy;
      m_rd   = m_pop && sz >= 2;
      m_wr   = m_push && !(sz == 0 || (sz == 1 && m_pop));
      check("m_count", count, sz);
      check("m_pop_valid", fif.pop_valid, sz > 0);
      check("m_push_ready", fif.push_ready, m_prdy);
      check("m_ram_en", ram_en, m_rd || m_wr);
      check("m_ram_we", ram_we, m_wr);
      if (sz > 0) check("m_pop_data", fif.pop_data, mq[0]);
      if (m_wr) check("m_wr_addr", ram_addr, wr_total % 4);
      if (m_rd) check("m_rd_addr", ram_addr, rd_total % 4);
      if (m_wr) check("m_ram_din", ram_din, s_data);
`ifdef COMMON_DFFRAM_FIFO_ERRCHK_EN
      check("m_err", err, exp_err);
      if ((fif.push_valid && !m_prdy && sz == 5) || (fif.pop_ready && sz == 0)) n_err = 1;
`endif
    end
    @(posedge clk);
    if (s_reset || s_flush) begin
      mq.delete(); wr_total = 0; rd_total = 0; exp_err = 0;
      if (s_reset) model_init = 1;
    end else if (model_init) begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(s_data);
      if (m_wr) wr_total++;
      if (m_rd) rd_total++;
      exp_err = n_err;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fif.push_valid = 0; fif.pop_ready = 0; flush = 0;
  endtask

  task automatic push1(input logic [7:0] d);
    fif.push_valid = 1; fif.push_data = d; cyc(); fif.push_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, limit %0d", 100000);
    $fatal(1, "timeout");
  end

  initial begin
    int en_before;
    reset = 1; flush = 0; fif.push_valid = 0; fif.push_data = 0; fif.pop_ready = 0;
    cyc(); cyc();
    reset = 0;
    #1;
    check("rst_count", count, 0);
    check("rst_pop_valid", fif.pop_valid, 0);
    check("rst_push_ready", fif.push_ready, 1);
    check("rst_ram_en", ram_en, 0);
    ram_en_cycles = 0;

    // Push into an empty FIFO; the entry appears on pop_data one cycle later.
    push1(8'h11);
    #1;
    check("t1_pop_valid", fif.pop_valid, 1);
    check("t1_pop_data", fif.pop_data, 8'h11);
    check("t1_count", count, 1);
    check("t1_no_ram", ram_en_cycles, 0);
    fif.pop_ready = 1; cyc(); fif.pop_ready = 0;

    // Fill to capacity, then try a sixth push.
    wr_addrs.delete();
    fif.push_valid = 1;
    for (int i = 1; i <= 5; i++) begin
      fif.push_data = 8'(i); cyc();
    end
    fif.push_data = 8'h06;
    #1;
    check("t2_full_ready", fif.push_ready, 0);
    cyc();
    fif.push_valid = 0;
    #1;
    check("t2_count", count, 5);
    check("t2_head", fif.pop_data, 8'h01);
    check("t2_wr_n", wr_addrs.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < wr_addrs.size()) check("t2_wr_addr", wr_addrs[i], i);

    // Drain at one entry per cycle.
    fif.pop_ready = 1;
    for (int i = 1; i <= 5; i++) begin
      #1;
      check("t3_pop_data", fif.pop_data, 8'(i));
      check("t3_pop_valid", fif.pop_valid, 1);
      if (i < 5) check("t3_push_blocked", fif.push_ready, 0);
      if (i < 5) check("t3_refill_read", {ram_en, ram_we}, 2'b10);
      cyc();
    end
    fif.pop_ready = 0;
    #1;
    check("t3_count", count, 0);

    // Simultaneous push and pop with only the head occupied.
    push1(8'h33);
    en_before = ram_en_cycles;
    fif.push_valid = 1; fif.push_data = 8'hAA; fif.pop_ready = 1;
    cyc();
    idle();
    #1;
    check("t4_pop_data", fif.pop_data, 8'hAA);
    check("t4_count", count, 1);
    check("t4_no_ram", ram_en_cycles - en_before, 0);
    fif.pop_ready = 1; cyc(); fif.pop_ready = 0;

    // Occupancy 3..4 across pointer wrap.
    push1(8'h40); push1(8'h41); push1(8'h42);
    for (int i = 0; i < 20; i++) begin
      push1(8'(8'h43 + i));
      #1;
      check("t5_order", fif.pop_data, 8'(8'h40 + i));
      fif.pop_ready = 1; cyc(); fif.pop_ready = 0;
    end
    for (int i = 0; i < 10 && count != 0; i++) begin
      fif.pop_ready = 1; cyc();
    end
    fif.pop_ready = 0;
    #1;
    check("t5_drained", count, 0);

    // Flush with a push pending.
    push1(8'h50); push1(8'h51); push1(8'h52);
    flush = 1; fif.push_valid = 1; fif.push_data = 8'h99;
    #1;
    check("t6_push_ready", fif.push_ready, 0);
    check("t6_pop_valid", fif.pop_valid, 1);
    check("t6_ram_en", ram_en, 0);
    cyc();
    idle();
    #1;
    check("t6_count", count, 0);
    check("t6_pop_valid_after", fif.pop_valid, 0);

`ifdef COMMON_DFFRAM_FIFO_ERRCHK_EN
    fif.pop_ready = 1; cyc(); fif.pop_ready = 0;
    #1;
    check("t7_err_set", err, 1);
    flush = 1; cyc(); flush = 0;
    #1;
    check("t7_err_clr", err, 0);
`endif

    cyc(); cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
